// File: rtl/flags_pkg.sv
// Shared definitions for the status-flags register: flag bit positions,
// default width and the masked flag-write helper.
package flags_pkg;

    localparam int FLAG_W     = 4;
    localparam int FLAG_N     = 3;
    localparam int FLAG_Z     = 2;
    localparam int FLAG_C     = 1;
    localparam int FLAG_V     = 0;
    localparam int MAX_FLAG_W = 32;

    // Keep bits whose enable is low, take ALU bits whose enable is high.
    function automatic logic [MAX_FLAG_W-1:0] masked_write(
        input logic [MAX_FLAG_W-1:0] cur,
        input logic [MAX_FLAG_W-1:0] alu,
        input logic [MAX_FLAG_W-1:0] we
    );
        return (cur & ~we) | (alu & we);
    endfunction

endpackage

// File: rtl/flags_lifo.sv
// Save/restore storage for flag snapshots. Only legal operations reach this
// block; the parent decides whether a push or pop is accepted.
module flags_lifo
    import flags_pkg::*;
#(
    parameter int FLAG_W = flags_pkg::FLAG_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_en,
    input  logic                       pop_en,
    input  logic                       xchg_en,
    input  logic [FLAG_W-1:0]          wr_data,
    output logic [FLAG_W-1:0]          top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 1 << IDX_W;

    logic [FLAG_W-1:0] mem_r [MEM_N];
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  top_cnt_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;

    // Top-of-stack index; clamps to 0 when empty so the read stays in range.
    always_comb begin
        top_cnt_s = {CNT_W{1'b0}};
        if (count_r != {CNT_W{1'b0}}) begin
            top_cnt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            top_cnt_s = {CNT_W{1'b0}};
        end
        top_idx_s = top_cnt_s[IDX_W-1:0];
        if (push_en) begin
            wr_idx_s = count_r[IDX_W-1:0];
        end else begin
            wr_idx_s = top_idx_s;
        end
    end

    // Storage and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem_r[i] <= {FLAG_W{1'b0}};
            end
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_en || xchg_en) begin
                mem_r[wr_idx_s] <= wr_data;
            end
            if (push_en) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (pop_en) begin
                count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign top_data = mem_r[top_idx_s];
    assign count    = count_r;
    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/flags_stack_reg.sv
// Processor status-flags register with masked ALU writes, a save/restore
// LIFO and sticky overflow/underflow error reporting.
module flags_stack_reg
    import flags_pkg::*;
#(
    parameter int                                FLAG_W    = flags_pkg::FLAG_W,
    parameter int                                DEPTH     = 4,
    parameter logic [FLAG_W-1:0]                 RESET_VAL = {FLAG_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FLAG_W-1:0]          alu_flags,
    input  logic [FLAG_W-1:0]          flag_we,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [FLAG_W-1:0]          cur_flags,
    output logic [$clog2(DEPTH+1)-1:0] stack_count,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       err_ovf,
    output logic                       err_unf
);

    logic [FLAG_W-1:0]     cur_flags_r;
    logic                  err_ovf_r;
    logic                  err_unf_r;
    logic [MAX_FLAG_W-1:0] wide_nxt_s;
    logic [FLAG_W-1:0]     nxt_s;
    logic [FLAG_W-1:0]     cur_next_s;
    logic [FLAG_W-1:0]     top_data_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  do_push_s;
    logic                  do_pop_s;
    logic                  do_xchg_s;
    logic                  ovf_evt_s;
    logic                  unf_evt_s;

    // Legality decode and next-flag selection; a restore overrides the ALU write.
    always_comb begin
        wide_nxt_s = masked_write(MAX_FLAG_W'(cur_flags_r), MAX_FLAG_W'(alu_flags),
                                  MAX_FLAG_W'(flag_we));
        nxt_s      = wide_nxt_s[FLAG_W-1:0];
        do_push_s  = push && !pop && !full_s;
        do_pop_s   = pop && !push && !empty_s;
        do_xchg_s  = push && pop && !empty_s;
        ovf_evt_s  = push && !pop && full_s;
        unf_evt_s  = pop && empty_s;
        if (do_pop_s || do_xchg_s) begin
            cur_next_s = top_data_s;
        end else begin
            cur_next_s = nxt_s;
        end
    end

    flags_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk      (clk),
        .reset    (reset),
        .push_en  (do_push_s),
        .pop_en   (do_pop_s),
        .xchg_en  (do_xchg_s),
        .wr_data  (cur_flags_r),
        .top_data (top_data_s),
        .count    (stack_count),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Current flags and sticky errors; a new error event beats err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_flags_r <= RESET_VAL;
            err_ovf_r   <= 1'b0;
            err_unf_r   <= 1'b0;
        end else begin
            cur_flags_r <= cur_next_s;
            if (ovf_evt_s) begin
                err_ovf_r <= 1'b1;
            end else if (err_clr) begin
                err_ovf_r <= 1'b0;
            end else begin
                err_ovf_r <= err_ovf_r;
            end
            if (unf_evt_s) begin
                err_unf_r <= 1'b1;
            end else if (err_clr) begin
                err_unf_r <= 1'b0;
            end else begin
                err_unf_r <= err_unf_r;
            end
        end
    end

    assign cur_flags   = cur_flags_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign err_ovf     = err_ovf_r;
    assign err_unf     = err_unf_r;

endmodule

// File: tb/tb_flags_stack_reg.sv
// Directed self-checking bench for flags_stack_reg (FLAG_W=4, DEPTH=4).
module tb_flags_stack_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_flags;
    logic [3:0] flag_we;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [3:0] cur_flags;
    logic [2:0] stack_count;
    logic       stack_full;
    logic       stack_empty;
    logic       err_ovf;
    logic       err_unf;

    int checks = 0;
    int errors = 0;

    flags_stack_reg #(
        .FLAG_W    (4),
        .DEPTH     (4),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_flags   (alu_flags),
        .flag_we     (flag_we),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .cur_flags   (cur_flags),
        .stack_count (stack_count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic [3:0] alu, input logic [3:0] we,
                        input logic ps, input logic pp, input logic clr);
        reset = rst; alu_flags = alu; flag_we = we; push = ps; pop = pp; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] cur, input logic [2:0] cnt,
                               input logic ovf, input logic unf);
        check({tag, ".cur"}, 32'(cur_flags), 32'(cur));
        check({tag, ".cnt"}, 32'(stack_count), 32'(cnt));
        check({tag, ".empty"}, 32'(stack_empty), 32'(cnt == 3'd0));
        check({tag, ".full"}, 32'(stack_full), 32'(cnt == 3'd4));
        check({tag, ".ovf"}, 32'(err_ovf), 32'(ovf));
        check({tag, ".unf"}, 32'(err_unf), 32'(unf));
    endtask

    initial begin
        step(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_state("reset_push", 4'b0000, 3'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_state("reset_rel", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Masked write
        step(1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
        check_state("mw1", 4'b0101, 3'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
        check_state("mw2", 4'b0101, 3'd0, 1'b0, 1'b0);

        // Nested save/restore
        step(1'b0, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_state("nest_push1", 4'b1000, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0);
        check_state("nest_w3", 4'b0010, 3'd2, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        check_state("nest_pop1", 4'b0100, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("nest_pop2", 4'b1000, 3'd0, 1'b0, 1'b0);

        // Push with simultaneous write
        step(1'b0, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_state("pushw", 4'b0001, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("pushw_pop", 4'b1010, 3'd0, 1'b0, 1'b0);

        // Overflow: entries 1010,0001,0010,0011; fifth push rejected
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_state("fill4", 4'b0100, 3'd4, 1'b0, 1'b0);
        step(1'b0, 4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_state("ovf", 4'b0101, 3'd4, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("drain3", 4'b0011, 3'd3, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("drain2", 4'b0010, 3'd2, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("drain1", 4'b0001, 3'd1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("drain0", 4'b1010, 3'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0110, 4'b0011, 1'b0, 1'b1, 1'b0);
        check_state("unf", 4'b1010, 3'd0, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_state("errclr", 4'b1010, 3'd0, 1'b0, 1'b0);

        // Error event wins over err_clr in the same cycle
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        check_state("unf_vs_clr", 4'b1010, 3'd0, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_state("errclr2", 4'b1010, 3'd0, 1'b0, 1'b0);

        // Exchange
        step(1'b0, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
        check_state("xchg_pre", 4'b0011, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        check_state("xchg", 4'b1100, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("xchg_top", 4'b0011, 3'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0110, 4'b1111, 1'b1, 1'b1, 1'b0);
        check_state("xchg_empty", 4'b0110, 3'd0, 1'b0, 1'b1);

        // Reset mid-sequence discards saved entries
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_state("pre_rst", 4'b0110, 3'd2, 1'b0, 1'b1);
        step(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
        check_state("mid_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check_state("post_rst_pop", 4'b0000, 3'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flags_stack_reg.md
# flags_stack_reg

Clocked, parametrised processor status-flags register with a save/restore LIFO. It sits between the ALU flag outputs and the ALU flag inputs.
- The ALU writes flags under a per-bit mask.
- A push saves the current flags and a pop restores them, e.g. around interrupts or subroutine calls.
- Stack overflow and underflow are reported through sticky error bits.

## Interface
- FLAG_W, 4: flag vector width; bit order {N,Z,C,V}, MSB first.
- DEPTH, 4: LIFO entries; ≥1.
- RESET_VAL, 0: value of cur_flags after reset.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_flags  in  FLAG_W  new flag values from the ALU.
- flag_we  in  FLAG_W  per-bit write enable for alu_flags.
- push  in  1  save cur_flags onto the LIFO.
- pop  in  1  restore cur_flags from the LIFO top.
- err_clr  in  1  clear both sticky error bits.
- cur_flags  out  FLAG_W  registered current flags; this feeds the ALU flag input.
- stack_count  out  $clog2(DEPTH+1)  number of valid LIFO entries.
- stack_full  out  1  stack_count == DEPTH.
- stack_empty  out  1  stack_count == 0.
- err_ovf  out  1  sticky; set when a push is rejected.
- err_unf  out  1  sticky; set when a pop is rejected.

## Operation
- Definition: masked write, nxt = (cur_flags & ~flag_we) | (alu_flags & flag_we).
- Idle (no push, no pop): cur_flags <= masked write.
- Push only, not full:
  - the pre-write cur_flags goes to entry[count], and count increments;
  - cur_flags <= masked write.
- Push only, full:
  - LIFO and count unchanged; err_ovf <= 1;
  - the masked write still applies.
- Pop only, not empty:
  - cur_flags <= entry[count-1], and count decrements;
  - the masked write is discarded, because the restore wins.
- Pop only, empty:
  - count unchanged; err_unf <= 1;
  - the masked write applies.
- Push+pop, not empty (exchange):
  - cur_flags <= entry[count-1];
  - entry[count-1] <= pre-write cur_flags;
  - count unchanged; the masked write is discarded.
- Push+pop, empty: behaves exactly as a pop on empty (err_unf <= 1, masked write applies, no push).
- Sticky errors:
  - err_clr clears both bits;
  - an error event in the same cycle as err_clr wins, so the bit stays set.
- Entries at index ≥ count are don't-care and are never visible.

## Timing
- Every output is registered, or decoded from registered count only.
- No combinational path from inputs to outputs.
- Write, push, pop and exchange effects are visible on cur_flags and stack_count the cycle after the sampling edge.
- Back-to-back pushes and pops are legal every cycle; there is no handshake and no stall.
- Reset values:
  - cur_flags = RESET_VAL;
  - stack_count = 0, stack_empty = 1, stack_full = 0;
  - err_ovf = err_unf = 0;
  - LIFO storage is cleared to 0.
- Reset has priority over all other inputs in the same cycle.
- Reset mid-sequence discards all saved entries.
- Pointer arithmetic never wraps.
  - Count stays within 0..DEPTH.
  - Rejected operations leave count untouched.

## Structure
- Package flags_pkg holds:
  - FLAG_W default;
  - bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the masked-write function.
- One sub-module, flags_lifo (parameters FLAG_W, DEPTH).
  - It holds the storage array, count, full/empty, and push/pop/exchange ports.
  - It accepts only legal operations; flags_stack_reg owns error detection and the cur_flags register.
- No other hierarchy.

## Test plan
- Reset, then release → cur_flags=0000, count=0, empty=1, errors=0. Assert reset with push=1 → count stays 0.
- Masked write: cur=0000, alu_flags=1111, flag_we=0101 → cur=0101. Next cycle alu_flags=0000, flag_we=1000 → cur=0101.
- Nested save/restore, DEPTH=4:
  - write 1000, push; write 0100, push; write 0010;
  - pop → cur=0100, count=1; pop → cur=1000, count=0.
- Push with write in the same cycle: cur=1010, push, alu_flags=0001, flag_we=1111 → cur=0001, entry0=1010. Pop → cur=1010.
- Overflow/underflow:
  - five pushes at DEPTH=4 → count=4, full=1, err_ovf=1, contents unchanged;
  - pops to empty, then one extra pop → err_unf=1, count=0;
  - err_clr → both bits clear.
- Exchange: cur=0011, top=1100, push+pop → cur=1100, top=0011, count unchanged. Push+pop when empty → err_unf=1, masked write applied.
